// File: rtl/text_scroll_disp.sv
// rtl/text_scroll_disp.sv - buffered ASCII message renderer with a scrolling 6-row glyph window
module text_scroll_disp #(
    parameter int CHARS      = 16,
    parameter int WIN_COLS   = 12,
    parameter int SCROLL_DIV = 1_200_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         scroll_en,
    input  logic                         wr_valid,
    input  logic [7:0]                   wr_data,
    output logic                         wr_ready,
    output logic [6*WIN_COLS-1:0]        frame,
    output logic                         frame_valid,
    output logic [$clog2(CHARS+1)-1:0]   len
);

    localparam int LW = $clog2(CHARS + 1);
    localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam int TW = $clog2(SCROLL_DIV);
    localparam int KW = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;
    localparam logic [LW-1:0] CHARS_L  = LW'(CHARS);
    localparam logic [TW-1:0] TICK_MAX = TW'(SCROLL_DIV - 1);
    localparam logic [KW-1:0] K_MAX    = KW'(WIN_COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RENDER, S_LOAD} state_t;

    state_t                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [LW-1:0]         len_q, len_d;
    logic [CW-1:0]         pos_char_q, pos_char_d;
    logic [2:0]            pos_col_q, pos_col_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [CW-1:0]         walk_char_q, walk_char_d;
    logic [2:0]            walk_col_q, walk_col_d;
    logic [KW-1:0]         kidx_q, kidx_d;
    logic [6*WIN_COLS-1:0] shadow_q, shadow_d;
    logic [6*WIN_COLS-1:0] frame_q, frame_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [7:0]            mem_q [CHARS];

    logic                  wr_fire;
    logic                  step;
    logic [7:0]            cur_code;
    logic [41:0]           cur_glyph;
    logic [5:0]            shamt;
    logic [5:0]            cur_col;

    // Columns packed col5..col0, two octal digits per column, bit 0 = top row.
    function automatic logic [35:0] glyph(input logic [7:0] code);
        logic [7:0] u;
        u = (code >= 8'h61 && code <= 8'h7A) ? code - 8'h20 : code;
        case (u)
            8'h21: glyph = 36'o000000570000;
            8'h2D: glyph = 36'o001010101000;
            8'h2E: glyph = 36'o000000400000;
            8'h30: glyph = 36'o003645516136;
            8'h31: glyph = 36'o000040774200;
            8'h32: glyph = 36'o004651515162;
            8'h33: glyph = 36'o002651514122;
            8'h34: glyph = 36'o001077101017;
            8'h35: glyph = 36'o003145454547;
            8'h36: glyph = 36'o002251515136;
            8'h37: glyph = 36'o000305710101;
            8'h38: glyph = 36'o002651515126;
            8'h39: glyph = 36'o007611111106;
            8'h3A: glyph = 36'o000000220000;
            8'h41: glyph = 36'o007611111176;
            8'h42: glyph = 36'o002651515177;
            8'h43: glyph = 36'o002241414136;
            8'h44: glyph = 36'o003641414177;
            8'h45: glyph = 36'o004151515177;
            8'h46: glyph = 36'o000111111177;
            8'h47: glyph = 36'o007251514136;
            8'h48: glyph = 36'o007710101077;
            8'h49: glyph = 36'o004141774141;
            8'h4A: glyph = 36'o003740404020;
            8'h4B: glyph = 36'o004142241077;
            8'h4C: glyph = 36'o004040404077;
            8'h4D: glyph = 36'o007702040277;
            8'h4E: glyph = 36'o007710040277;
            8'h4F: glyph = 36'o003641414136;
            8'h50: glyph = 36'o000611111177;
            8'h51: glyph = 36'o005621514136;
            8'h52: glyph = 36'o004631111177;
            8'h53: glyph = 36'o003151515146;
            8'h54: glyph = 36'o000101770101;
            8'h55: glyph = 36'o003740404037;
            8'h56: glyph = 36'o001720402017;
            8'h57: glyph = 36'o007720102077;
            8'h58: glyph = 36'o006112041261;
            8'h59: glyph = 36'o000304700403;
            8'h5A: glyph = 36'o004143455161;
            default: glyph = 36'o0;
        endcase
    endfunction

    function automatic logic [CW-1:0] next_char(input logic [CW-1:0] c, input logic [LW-1:0] n);
        logic [LW-1:0] c1;
        c1 = LW'(c) + LW'(1);
        return (c1 >= n) ? '0 : CW'(c1);
    endfunction

    // Column 6 lands in the zero-padded top slice, giving the blank spacer for free.
    assign cur_code  = (len_q == '0) ? 8'h20 : mem_q[walk_char_q];
    assign cur_glyph = {6'b0, glyph(cur_code)};
    assign shamt     = {1'b0, walk_col_q, 2'b00} + {2'b00, walk_col_q, 1'b0};
    assign cur_col   = cur_glyph[shamt +: 6];

    assign wr_ready    = (state_q == S_IDLE) && !pending_q && !clear && (len_q < CHARS_L);
    assign wr_fire     = wr_valid && wr_ready;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign len         = len_q;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        len_d         = len_q;
        pos_char_d    = pos_char_q;
        pos_col_d     = pos_col_q;
        tick_d        = tick_q;
        walk_char_d   = walk_char_q;
        walk_col_d    = walk_col_q;
        kidx_d        = kidx_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        step          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    pending_d   = 1'b0;
                    state_d     = S_RENDER;
                    walk_char_d = pos_char_q;
                    walk_col_d  = pos_col_q;
                    kidx_d      = '0;
                end
            end
            S_RENDER: begin
                for (int k = 0; k < WIN_COLS; k++) begin
                    if (kidx_q == KW'(k)) shadow_d[6*k +: 6] = cur_col;
                end
                if (walk_col_q == 3'd6) begin
                    walk_col_d  = 3'd0;
                    walk_char_d = next_char(walk_char_q, len_q);
                end else begin
                    walk_col_d = walk_col_q + 3'd1;
                end
                kidx_d = kidx_q + KW'(1);
                if (kidx_q == K_MAX) state_d = S_LOAD;
            end
            S_LOAD: begin
                frame_d       = shadow_q;
                frame_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (scroll_en && len_q != '0) begin
            if (tick_q == TICK_MAX) begin
                tick_d = '0;
                step   = 1'b1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end else begin
            tick_d = '0;
        end

        if (step) begin
            pending_d = 1'b1;
            if (pos_col_q == 3'd6) begin
                pos_col_d  = 3'd0;
                pos_char_d = next_char(pos_char_q, len_q);
            end else begin
                pos_col_d = pos_col_q + 3'd1;
            end
        end

        if (wr_fire) begin
            len_d     = len_q + LW'(1);
            pending_d = 1'b1;
        end

        // Clear wins over a same-cycle write or scroll step; an in-flight render still finishes.
        if (clear) begin
            len_d      = '0;
            pos_char_d = '0;
            pos_col_d  = 3'd0;
            tick_d     = '0;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pending_q     <= 1'b1;
            len_q         <= '0;
            pos_char_q    <= '0;
            pos_col_q     <= 3'd0;
            tick_q        <= '0;
            walk_char_q   <= '0;
            walk_col_q    <= 3'd0;
            kidx_q        <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            len_q         <= len_d;
            pos_char_q    <= pos_char_d;
            pos_col_q     <= pos_col_d;
            tick_q        <= tick_d;
            walk_char_q   <= walk_char_d;
            walk_col_q    <= walk_col_d;
            kidx_q        <= kidx_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[len_q[CW-1:0]] <= wr_data;
    end

endmodule
